// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared constants and types for the board row fetch scheduler
package board_pkg;

    localparam int COLS    = 12;
    localparam int ROWS    = 22;
    localparam int CELL_PX = 20;
    localparam int COLOR_W = 4;
    localparam int ADDR_W  = 9;

    // Wide enough for both 0..ROWS-1 and 0..CELL_PX-1
    localparam int ROW_W   = 5;
    // Wide enough for 0..COLS-1
    localparam int COL_W   = 4;

    typedef logic [COLOR_W-1:0] cell_color_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } fetch_state_t;

endpackage

// File: rtl/board_row_tracker.sv
// rtl/board_row_tracker.sv - tracks board cell row per pixel line and raises the fetch trigger
module board_row_tracker
    import board_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start_i,
    input  logic [9:0]       next_row_i,
    output logic [ROW_W-1:0] cell_row_o,
    output logic             in_board_o,
    output logic             trigger_o
);

    logic [ROW_W-1:0] sub_row_q, sub_row_d;
    logic [ROW_W-1:0] cell_row_q, cell_row_d;

    // Counter update on each line start; next_row 0 resynchronises to the frame top
    always_comb begin
        sub_row_d  = sub_row_q;
        cell_row_d = cell_row_q;
        if (line_start_i) begin
            if (next_row_i == '0) begin
                sub_row_d  = '0;
                cell_row_d = '0;
            end else if (sub_row_q == ROW_W'(CELL_PX - 1)) begin
                sub_row_d = '0;
                if (cell_row_q != ROW_W'(ROWS - 1)) begin
                    cell_row_d = cell_row_q + 1'b1;
                end
            end else begin
                sub_row_d = sub_row_q + 1'b1;
            end
        end
    end

    // Row counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_row_q  <= '0;
            cell_row_q <= '0;
        end else begin
            sub_row_q  <= sub_row_d;
            cell_row_q <= cell_row_d;
        end
    end

    // Post-update values drive the trigger so the fetch targets the row about to be shown
    always_comb begin
        in_board_o = (next_row_i < 10'(ROWS * CELL_PX));
        cell_row_o = cell_row_d;
        trigger_o  = line_start_i && in_board_o && (sub_row_d == '0);
    end

endmodule

// File: rtl/board_row_fetch_sched.sv
// rtl/board_row_fetch_sched.sv - arbitrates board RAM between display row bursts and the game engine
module board_row_fetch_sched
    import board_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     line_start,
    input  logic [9:0]               next_row,
    input  logic                     game_req,
    input  logic                     game_we,
    input  logic [ADDR_W-1:0]        game_addr,
    input  logic [COLOR_W-1:0]       game_wdata,
    output logic                     game_gnt,
    output logic                     game_rvalid,
    output logic [COLOR_W-1:0]       game_rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [COLOR_W-1:0]       ram_wdata,
    input  logic [COLOR_W-1:0]       ram_rdata,
    output logic [COLS*COLOR_W-1:0]  line_cells,
    output logic                     line_valid,
    output logic                     fetch_busy,
    output logic                     overrun
);

    fetch_state_t             state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic                     rd_pend_q;
    logic [COL_W-1:0]         rd_col_q;
    logic [COLS*COLOR_W-1:0]  shadow_q;
    logic [COLS*COLOR_W-1:0]  line_cells_q;
    logic                     line_valid_q;
    logic                     overrun_q;
    logic                     game_rvalid_q;

    logic [ROW_W-1:0]         cell_row;
    logic                     in_board;
    logic                     trigger;

    board_row_tracker u_tracker (
        .clk          (clk),
        .reset        (reset),
        .line_start_i (line_start),
        .next_row_i   (next_row),
        .cell_row_o   (cell_row),
        .in_board_o   (in_board),
        .trigger_o    (trigger)
    );

    // Burst sequencing: issue one column per cycle, wait out the last read, then publish
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        base_d     = base_q;
        fetch_busy = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = FETCH;
                    col_d   = '0;
                    base_d  = ADDR_W'(cell_row) * ADDR_W'(COLS);
                end
            end
            FETCH: begin
                if (col_q == COL_W'(COLS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN:   state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port mux: display burst owns the RAM, the game engine only gets quiet IDLE cycles
    always_comb begin
        game_gnt  = game_req && (state_q == IDLE) && !trigger;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == FETCH) begin
            ram_en   = 1'b1;
            ram_addr = base_q + ADDR_W'(col_q);
        end else if (game_gnt) begin
            ram_en    = 1'b1;
            ram_we    = game_we;
            ram_addr  = game_addr;
            ram_wdata = game_wdata;
        end
    end

    // FSM and burst address registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            base_q  <= base_d;
        end
    end

    // Read data lands one cycle after issue, so it is steered by the delayed column index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_col_q  <= '0;
            shadow_q  <= '0;
        end else begin
            rd_pend_q <= (state_q == FETCH);
            rd_col_q  <= col_q;
            if (rd_pend_q) begin
                shadow_q[rd_col_q*COLOR_W +: COLOR_W] <= ram_rdata;
            end
        end
    end

    // Visible line buffer: blanked when leaving the board, otherwise replaced whole at commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_cells_q <= '0;
            line_valid_q <= 1'b0;
        end else if (line_start && !in_board) begin
            line_cells_q <= '0;
            line_valid_q <= 1'b0;
        end else if (state_q == COMMIT) begin
            line_cells_q <= shadow_q;
            line_valid_q <= 1'b1;
        end
    end

    // Sticky overrun flag and game read-valid pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q     <= 1'b0;
            game_rvalid_q <= 1'b0;
        end else begin
            if (line_start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            game_rvalid_q <= game_gnt && !game_we;
        end
    end

    assign line_cells  = line_cells_q;
    assign line_valid  = line_valid_q;
    assign overrun     = overrun_q;
    assign game_rvalid = game_rvalid_q;
    assign game_rdata  = game_rvalid_q ? ram_rdata : '0;

endmodule

// File: doc/board_row_fetch_sched.md
Name: board_row_fetch_sched

Overview:
- Schedules access to the single-port Tetris board RAM (22 rows x 12 cells, 4-bit colour code per cell).
- Two requesters share the RAM: the VGA display path and the game engine.
- At each line start, the block tracks which board row the next pixel line falls in. When that is a new 20-pixel cell row, it burst-reads the 12 cells into a line buffer that feeds the 20x pixel upscaler.
- Outside display bursts, the block grants the RAM to the game engine for single-cell reads and writes.

Parameters:
- COLS, 12, cells per board row
- ROWS, 22, board rows
- CELL_PX, 20, screen pixels per cell edge (vertical repeat count)
- COLOR_W, 4, bits per cell colour code
- ADDR_W, 9, RAM address width (ROWS*COLS = 264 ≤ 512)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line_start  in  1  one-cycle pulse at start of h-blank preceding pixel row next_row
- next_row  in  10  pixel row about to be displayed (0..524)
- game_req  in  1  game engine access request
- game_we  in  1  1 = write, 0 = read
- game_addr  in  ADDR_W  cell address = row*COLS + col
- game_wdata  in  COLOR_W  write data
- game_gnt  out  1  request accepted this cycle
- game_rvalid  out  1  game_rdata valid (read only)
- game_rdata  out  COLOR_W  read data
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  COLOR_W  RAM write data
- ram_rdata  in  COLOR_W  RAM read data, 1-cycle latency after ram_en
- line_cells  out  COLS*COLOR_W  current board row; cell c at bits [c*COLOR_W +: COLOR_W]
- line_valid  out  1  line_cells holds a board row (0 = outside board, display black)
- fetch_busy  out  1  display burst in progress
- overrun  out  1  sticky: line_start arrived while a burst was in progress

Behaviour:
- Reset (async, active-high) clears all of the following: all outputs, the line buffer, the shadow buffer, cell_row, sub_row and overrun. FSM goes to IDLE.
- Row tracking happens on each line_start. No divider is used.
  - If next_row == 0: cell_row = 0, sub_row = 0.
  - Otherwise sub_row increments. When it reaches CELL_PX it wraps to 0 and cell_row increments.
  - in_board = next_row < ROWS*CELL_PX (440).
- Fetch is triggered on line_start when sub_row (post-update) == 0 and in_board. Otherwise no RAM traffic occurs for that line.
- Leaving the board: on line_start with !in_board, line_valid falls to 0 the next cycle and line_cells is zeroed.
- FSM states and transitions:
  - IDLE -> FETCH on trigger.
  - FETCH: issues reads for col = 0..COLS-1 on consecutive cycles, at ram_addr = cell_row*COLS + col.
  - After col COLS-1 is issued -> DRAIN, which captures the final ram_rdata.
  - DRAIN -> COMMIT. COMMIT copies the shadow buffer to line_cells and sets line_valid = 1.
  - COMMIT -> IDLE.
- Each ram_rdata is stored at the shadow slot of the column issued in the previous cycle (delayed column index).
- Latency: with line_start at cycle 0, reads are issued in cycles 1..12 and line_cells/line_valid update at the end of cycle 14. fetch_busy = 1 in FETCH, DRAIN and COMMIT.
- line_cells changes only in COMMIT. The display never sees a partially filled row.
- Arbitration: the display has absolute priority.
  - game_gnt = game_req && state == IDLE && !trigger (combinational).
  - When granted, the RAM is driven from the game port in the same cycle.
  - For reads, game_rvalid pulses exactly one cycle later, with game_rdata = ram_rdata.
  - An ungranted request must be held by the engine. There is no queue.
- Simultaneous trigger and game_req in IDLE: the display wins and game_gnt = 0.
- line_start while not in IDLE: overrun is set (sticky until reset). Row counters still update, but no new burst starts and the current burst completes normally.
- cell_row saturates at ROWS-1. Addresses never exceed ROWS*COLS-1.
- Reset mid-burst: immediate return to IDLE, line_valid = 0, no ram_en.

Decomposition:
- Package board_pkg holds:
  - the COLS/ROWS/CELL_PX/COLOR_W/ADDR_W constants;
  - the cell_color_t typedef (logic [COLOR_W-1:0]);
  - the fetch_state_t enum {IDLE, FETCH, DRAIN, COMMIT}.
- One natural sub-module: board_row_tracker, containing the sub_row/cell_row counters, the in_board compare and the trigger generation.

Test Plan:
- Reset, then line_start with next_row=0 and a RAM preloaded with cell k = k mod 16:
  - ram_addr 0..11 in cycles 1..12;
  - line_cells = 0xBA9876543210 at cycle 14;
  - line_valid = 1.
- line_start for next_row = 1..19 -> no ram_en. At next_row = 20, reads at addr 12..23; at next_row = 420, reads at addr 252..263.
- next_row = 440 -> line_valid = 0 and line_cells = 0 the next cycle, with no RAM access.
- game write (addr 5, data 0xC) in IDLE -> game_gnt = 1 and ram_we = 1 the same cycle. A game read of addr 5 then gives game_rvalid one cycle later with game_rdata = 0xC.
- game_req held across a burst started at the same cycle -> game_gnt = 0 through cycle 14, then 1 in the first IDLE cycle.
- Second line_start at cycle 5 of a burst -> overrun = 1 and the burst completes at cycle 14. Separately, asserting reset at cycle 6 -> IDLE, line_valid = 0, no further ram_en.
